rx_frame_ctrl: RTL
==================

# rx_frame_ctrl

Frame-level controller for the serial receive path. It synchronises the raw serial line, detects and qualifies start bits, and sequences bit sampling at a programmed bit period. It checks parity and stop bits, and hands completed bytes to the consumer over a valid/ready interface. It sits between the pin-level `rx_data` line and the downstream byte consumer, and reports `frame_err` and `overrun` events.

## Interface
- `CLKS_PER_BIT`, default 5: clocks per serial bit; legal values are 4 or more.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first; legal range 5–9.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data and stop bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: gates detection of new frames only.
- `rx_data`  in  1: serial line, idle high, asynchronous to `clk`.
- `rx_start`  out  1: one-cycle pulse when a start bit is confirmed.
- `busy`  out  1: high in every state except IDLE.
- `out_data`  out  DATA_BITS: received byte, held stable while `out_valid` is high.
- `out_valid`  out  1: byte available.
- `out_ready`  in  1: consumer accepts the byte when `out_valid && out_ready`.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit or parity error.
- `overrun`  out  1: one-cycle pulse when a good frame is dropped.

## Operation
- `rx_data` passes through a 2-flop synchroniser to give `rxs`. A start edge is `rxs==0` while the previous `rxs==1`.
- States:
  - IDLE: on a start edge with `en=1`, go to START and clear the counter.
  - START: at count H = CLKS_PER_BIT/2 (floor), sample `rxs`. If it is 1, this is a false start: go to IDLE with no pulse. If it is 0, pulse `rx_start`, clear the counter and the bit index, and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, shift `rxs` into the MSB of the shift register (LSB-first reception). After DATA_BITS samples, go to PARITY if PARITY_EN, otherwise go to STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit. It is an error if the XOR of the data and parity bits is 1. Then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`, then go to IDLE unconditionally.
- At the STOP sample:
  - If the stop bit is 0 or a parity error occurred: pulse `frame_err`, discard the byte, do not pulse `overrun`.
  - Otherwise the frame is good: load the output register.
- Output register is one entry deep:
  - Empty (`out_valid=0`): load the byte and set `out_valid`.
  - Full and `out_ready=1` in the same cycle: the old byte is consumed and the new byte is loaded, so `out_valid` stays 1.
  - Full and `out_ready=0`: pulse `overrun`, keep the old byte, drop the new one.
- `out_valid` falls on the cycle after a handshake when no new byte is loaded.
- Deasserting `en` mid-frame does not abort the frame; the frame completes.
- From IDLE, a new start edge is accepted on the cycle after STOP exits.
- Reset mid-frame: all state is cleared immediately; any pending byte is lost.
- Counters:
  - Bit counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at each sample.
  - Bit index is $clog2(DATA_BITS+1) bits.
  - No arithmetic overflow is possible inside the legal parameter ranges.

## Timing
- Reset values: `rx_start=0`, `busy=0`, `out_data=0`, `out_valid=0`, `frame_err=0`, `overrun=0`. State is IDLE and all counters are 0.
- Synchroniser latency is 2 cycles from the `rx_data` change to the `rxs` change.
- Let t0 be the start-edge cycle and C = CLKS_PER_BIT.
  - Start sample at t0+H; `rx_start` is high in cycle t0+H+1.
  - Data bit i (0-based) is sampled at t0+H+(i+1)·C.
  - Stop bit is sampled at t0+H+(DATA_BITS+1+PARITY_EN)·C.
  - `out_valid`, `frame_err` and `overrun` assert on the cycle after the stop sample.
- `busy` rises the cycle after t0 and falls the cycle after the stop sample.
- All outputs are registered.

## Structure
- Package `rx_pkg`: state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP) and the parameter-legality constants.
- Sub-module `rx_sync`: parameterised 2-flop synchroniser with `rst` forcing its output to 1 (idle).
- Top level contains the FSM, counters, shift register, parity accumulator and output register.

## Test plan
All scenarios use C=5 (H=2) and DATA_BITS=8 unless stated.

- Good frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with `out_ready=1` → `rx_start` pulses once, `out_data=0xA5` with a single-cycle `out_valid`, `frame_err=0`.
- Same frame with the stop bit driven 0 → one `frame_err` pulse, `out_valid` stays 0, state returns to IDLE.
- Glitch: `rx_data` low for 1 cycle then high → no `rx_start`, `busy` falls after H+1 cycles.
- Two back-to-back frames 0x3C then 0xC3 with `out_ready=0` → `out_data` stays 0x3C and `overrun` pulses once. Raising `out_ready` then gives exactly one handshake.
- PARITY_EN=1 with frame 0x07 and parity bit 0 → `frame_err` pulse. The same frame with parity bit 1 → `out_data=0x07`.
- Assert `rst` mid-DATA → all outputs return to reset values immediately; a subsequent good frame 0x5A is received correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and parameter limits for the serial receive frame controller.
//   rx_state_t    : receive FSM state encoding
//   params_legal  : elaboration check of CLKS_PER_BIT / DATA_BITS / PARITY_EN
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned MIN_CLKS_PER_BIT = 4;
    localparam int unsigned MIN_DATA_BITS    = 5;
    localparam int unsigned MAX_DATA_BITS    = 9;

    // True when the parameter set is inside the supported range.
    function automatic bit params_legal(input int unsigned clks_per_bit,
                                        input int unsigned data_bits,
                                        input int unsigned parity_en);
        return (clks_per_bit >= MIN_CLKS_PER_BIT) &&
               (data_bits >= MIN_DATA_BITS) &&
               (data_bits <= MAX_DATA_BITS) &&
               (parity_en <= 1);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; reset drives the output to
// all ones so an idle-high serial line never looks like a start edge.
//   clk, rst : clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronised output (2 cycles of latency)
module rx_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Serial receive frame controller: synchronises rx_data, qualifies start bits,
// samples data/parity/stop at mid-bit and hands good bytes to a one-deep
// valid/ready output register.
//   clk, rst   : clock, async active-high reset
//   en         : enables detection of new frames (a running frame completes)
//   rx_data    : serial line, idle high
//   rx_start   : pulse when a start bit is confirmed
//   busy       : receiver not idle
//   out_data / out_valid / out_ready : received byte handshake
//   frame_err  : pulse on bad stop bit or parity error
//   overrun    : pulse when a good frame is dropped because the output is full
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx_data,
    output logic                 rx_start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (!params_legal(CLKS_PER_BIT, DATA_BITS, PARITY_EN)) begin : g_param_check
        $error("rx_frame_ctrl: unsupported CLKS_PER_BIT/DATA_BITS/PARITY_EN");
    end

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    logic                 rxs, rxs_prev;
    logic                 start_edge_c;
    logic                 start_ok_c;
    logic                 stop_sample_c;

    // Line synchroniser plus one history flop for edge detection
    rx_sync #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_data),
        .q   (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rxs_prev <= 1'b1;
        else     rxs_prev <= rxs;
    end

    assign start_edge_c = rxs_prev & ~rxs;

    // State, counters, shift register and parity accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state and sampling decisions
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        perr_d        = perr_q;
        start_ok_c    = 1'b0;
        stop_sample_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && start_edge_c) begin
                    state_d = START;
                    // The edge cycle itself is tick 0, so the next cycle is tick 1.
                    cnt_d   = CNT_W'(1);
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        start_ok_c = 1'b1;
                        idx_d      = '0;
                        par_d      = 1'b0;
                        perr_d     = 1'b0;
                        state_d    = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ rxs;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = par_q ^ rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    stop_sample_c = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Registered status pulses and the one-deep output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_start  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_start  <= start_ok_c;
            busy      <= (state_d != IDLE);
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (stop_sample_c) begin
                if (!rxs || perr_q) begin
                    frame_err <= 1'b1;
                end else if (!out_valid || out_ready) begin
                    // Empty, or the held byte is consumed this same cycle.
                    out_data  <= shift_q;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
